// File: rtl/mu_mem_access_ctrl_pkg.sv
// Shared definitions for the multicycle memory-access controller:
// address map, controller states and the latched access request.
package MU_my_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [DATA_WIDTH-1:0] DATA_BASE = 32'h1001_0000;
  localparam logic [DATA_WIDTH-1:0] RAM_BOUND = 32'h1000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } mu_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic                  we;
    logic                  instr;
    logic [DATA_WIDTH-1:0] wdata;
  } mu_acc_req_t;

endpackage

// File: rtl/mu_addr_translate.sv
// Region check and MIPS virtual-to-memory-system word address translation.
// Purely combinational.
module mu_addr_translate #(
  parameter int                    DATA_WIDTH = MU_my_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = MU_my_pkg::TEXT_BASE,
  parameter logic [DATA_WIDTH-1:0] DATA_BASE  = MU_my_pkg::DATA_BASE,
  parameter logic [DATA_WIDTH-1:0] RAM_BOUND  = MU_my_pkg::RAM_BOUND
) (
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  instr,
  output logic [DATA_WIDTH-1:0] xaddr,
  output logic                  err
);

  logic in_text;
  logic in_data;
  logic [DATA_WIDTH-1:0] text_off;
  logic [DATA_WIDTH-1:0] data_off;

  assign in_data  = (addr >= DATA_BASE);
  assign in_text  = (addr >= TEXT_BASE) && !in_data;
  assign text_off = addr - TEXT_BASE;
  assign data_off = addr - DATA_BASE;

  always_comb begin
    err = 1'b0;
    if (addr[1:0] != 2'b00)  err = 1'b1;
    if (addr < TEXT_BASE)    err = 1'b1;
    if (in_text && we)       err = 1'b1;
    if (in_data && instr)    err = 1'b1;
  end

  // RAM words sit above RAM_BOUND; ROM words start at zero.
  assign xaddr = in_data ? (RAM_BOUND + (data_off >> 2)) : (text_off >> 2);

endmodule

// File: rtl/mu_mem_access_ctrl.sv
// Multicycle memory-access controller: accepts one fetch/load/store at a time,
// translates the address, waits the read latency and loads IR or MDR.
//
//   state | meaning
//   IDLE  | ready for a request
//   WRITE | store strobe to memory (one cycle)
//   WAIT  | counting read latency, capture on terminal count
//   DONE  | access complete, done pulse
//   ERR   | request rejected, done + err pulse
module mu_mem_access_ctrl #(
  parameter int                    DATA_WIDTH   = MU_my_pkg::DATA_WIDTH,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = MU_my_pkg::TEXT_BASE,
  parameter logic [DATA_WIDTH-1:0] DATA_BASE    = MU_my_pkg::DATA_BASE,
  parameter logic [DATA_WIDTH-1:0] RAM_BOUND    = MU_my_pkg::RAM_BOUND
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] ir_o,
  output logic [DATA_WIDTH-1:0] mdr_o,
  output logic                  done_o,
  output logic                  err_o
);

  import MU_my_pkg::*;

  mu_state_e             state_q, state_d;
  mu_acc_req_t           req_q;
  logic [1:0]            cnt_q;
  logic [DATA_WIDTH-1:0] ir_q, mdr_q;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] xaddr;
  logic                  xerr;
  logic                  accept;
  logic                  capture;

  assign sel_addr = req_instr_i ? pc_i : alu_addr_i;

  mu_addr_translate #(
    .DATA_WIDTH (DATA_WIDTH),
    .TEXT_BASE  (TEXT_BASE),
    .DATA_BASE  (DATA_BASE),
    .RAM_BOUND  (RAM_BOUND)
  ) u_xlate (
    .addr  (sel_addr),
    .we    (req_we_i),
    .instr (req_instr_i),
    .xaddr (xaddr),
    .err   (xerr)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          accept = 1'b1;
          if (xerr)          state_d = ERR;
          else if (req_we_i) state_d = WRITE;
          else               state_d = WAIT;
        end
      end
      WRITE: state_d = DONE;
      WAIT: begin
        if (cnt_q == 2'(READ_LATENCY)) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_q.addr holds the translated word address, so it drives mem_addr_o directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      req_q   <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == WAIT) ? cnt_q + 2'd1 : 2'd0;
      if (accept) begin
        req_q.addr  <= xaddr;
        req_q.we    <= req_we_i;
        req_q.instr <= req_instr_i;
        if (!xerr && req_we_i) req_q.wdata <= wdata_i;
      end
      if (capture) begin
        if (req_q.instr) ir_q  <= mem_rdata_i;
        else             mdr_q <= mem_rdata_i;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign mem_we_o    = (state_q == WRITE) && req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign done_o      = (state_q == DONE) || (state_q == ERR);
  assign err_o       = (state_q == ERR);
  assign ir_o        = ir_q;
  assign mdr_o       = mdr_q;

endmodule

// File: tb/tb_mu_mem_access_ctrl.sv
// Bench for mu_mem_access_ctrl: three instances (read latency 0, 1, 3) share
// stimulus; each access is scored against an address-map reference model.
module tb_mu_mem_access_ctrl;

  localparam logic [31:0] TB_TEXT = 32'h0040_0000;
  localparam logic [31:0] TB_DATA = 32'h1001_0000;
  localparam logic [31:0] TB_RAM  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  valid;
  logic        req_we, req_instr;
  logic [31:0] pc, alu_addr, wdata, mem_rdata;

  logic        ready [3];
  logic        mem_we [3];
  logic        done [3];
  logic        err [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] ir [3];
  logic [31:0] mdr [3];

  logic [31:0] ir_m [3];
  logic [31:0] mdr_m [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mu_mem_access_ctrl #(
      .READ_LATENCY ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (valid[g]),
      .req_ready_o (ready[g]),
      .req_we_i    (req_we),
      .req_instr_i (req_instr),
      .pc_i        (pc),
      .alu_addr_i  (alu_addr),
      .wdata_i     (wdata),
      .mem_rdata_i (mem_rdata),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_we_o    (mem_we[g]),
      .ir_o        (ir[g]),
      .mdr_o       (mdr[g]),
      .done_o      (done[g]),
      .err_o       (err[g])
    );
  end

  function automatic int rl_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic ref_err(input logic [31:0] a, input logic we, input logic instr);
    if (a % 4 != 0) return 1'b1;
    if (a < TB_TEXT) return 1'b1;
    if (a < TB_DATA) return we;
    return instr;
  endfunction

  function automatic logic [31:0] ref_xlate(input logic [31:0] a);
    if (a >= TB_DATA) return TB_RAM + (a - TB_DATA) / 4;
    return (a - TB_TEXT) / 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_ready(input int d);
    int t = 0;
    while (!ready[d] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!ready[d]) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      ir_m[i]  = '0;
      mdr_m[i] = '0;
    end
  endtask

  // One access on instance d; mem_rdata steps by 'step' each cycle so the
  // captured word identifies the capture edge.
  task automatic do_access(input int d, input logic instr, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rbase, input logic [31:0] step);
    int k, done_cyc, n_done, n_we, err_seen, exp_done;
    logic [31:0] addr_k1, wdata_seen, cap;
    logic e;
    wait_ready(d);
    pc        = instr ? addr : $urandom;
    alu_addr  = instr ? $urandom : addr;
    req_we    = we;
    req_instr = instr;
    wdata     = wd;
    mem_rdata = rbase;
    valid[d]  = 1'b1;
    @(negedge clk);
    valid[d]  = 1'b0;
    pc = $urandom; alu_addr = $urandom; wdata = $urandom;
    req_we = $urandom_range(0, 1); req_instr = $urandom_range(0, 1);
    k = 1; done_cyc = 0; n_done = 0; n_we = 0; err_seen = 0;
    addr_k1 = '0; wdata_seen = '0;
    while (k <= 12) begin
      if (k == 1) addr_k1 = mem_addr[d];
      if (done[d]) begin
        n_done++;
        if (done_cyc == 0) done_cyc = k;
        if (err[d]) err_seen++;
      end
      if (mem_we[d]) begin
        n_we++;
        wdata_seen = mem_wdata[d];
      end
      if (ready[d]) break;
      mem_rdata = rbase + step * k;
      @(negedge clk);
      k++;
    end
    if (!ready[d]) check("access_timeout", 32'd0, 32'd1);
    e = ref_err(addr, we, instr);
    if (e) exp_done = 1;
    else if (we) exp_done = 2;
    else exp_done = 2 + rl_of(d);
    check("done_cycle", done_cyc, exp_done);
    check("done_count", n_done, 1);
    check("err_flag", err_seen, e ? 1 : 0);
    check("we_count", n_we, (!e && we) ? 1 : 0);
    if (!e) check("mem_addr", addr_k1, ref_xlate(addr));
    if (!e && we) check("mem_wdata", wdata_seen, wd);
    if (!e && !we) begin
      cap = rbase + step * (1 + rl_of(d));
      if (instr) ir_m[d] = cap;
      else       mdr_m[d] = cap;
    end
    check("ir", ir[d], ir_m[d]);
    check("mdr", mdr[d], mdr_m[d]);
  endtask

  initial begin
    int nready, ndone;
    logic [31:0] a;
    rst_n = 1'b0; valid = '0; req_we = 0; req_instr = 0;
    pc = '0; alu_addr = '0; wdata = '0; mem_rdata = '0;
    reset_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_ready", ready[d], 1);
      check("rst_addr", mem_addr[d], 0);
      check("rst_wdata", mem_wdata[d], 0);
      check("rst_we", mem_we[d], 0);
      check("rst_ir", ir[d], 0);
      check("rst_mdr", mdr[d], 0);
      check("rst_done", done[d], 0);
      check("rst_err", err[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // fetch, store, load on the latency-1 instance
    do_access(1, 1, 0, 32'h0040_0008, 0, 32'h2008_0005, 0);
    check("fetch_ir_const", ir[1], 32'h2008_0005);
    do_access(1, 0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 0, 0);
    do_access(1, 0, 0, 32'h1001_0004, 0, 32'hDEAD_BEEF, 0);
    check("load_mdr_const", mdr[1], 32'hDEAD_BEEF);
    check("load_ir_kept", ir[1], 32'h2008_0005);

    // rejected requests
    do_access(1, 0, 0, 32'h1001_0002, 0, 32'h1111_1111, 0);
    do_access(1, 0, 1, 32'h0040_0000, 32'h5555_5555, 0, 0);
    do_access(1, 1, 0, 32'h1001_0000, 0, 32'h2222_2222, 0);
    do_access(1, 0, 0, 32'h0000_0010, 0, 32'h3333_3333, 0);

    // latency sweep with a stepping read bus
    do_access(0, 1, 0, 32'h0040_0100, 0, 32'hA000_0000, 1);
    do_access(2, 1, 0, 32'h0040_0200, 0, 32'hB000_0000, 1);
    do_access(0, 0, 0, 32'h1001_0040, 0, 32'hC000_0000, 3);
    do_access(2, 0, 0, 32'h1001_0080, 0, 32'hD000_0000, 3);

    // request held high on the latency-3 instance: one access per ready cycle
    wait_ready(2);
    pc = 32'h0040_0010; req_instr = 1; req_we = 0; mem_rdata = 32'h1234_5678;
    valid[2] = 1'b1;
    nready = 0; ndone = 0;
    for (int c = 0; c < 18; c++) begin
      if (ready[2]) nready++;
      if (done[2]) ndone++;
      if (c == 1) check("busy_ready_low", ready[2], 0);
      @(negedge clk);
    end
    valid[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done[2]) ndone++;
      @(negedge clk);
    end
    check("busy_ready_cycles", nready, 3);
    check("busy_done_count", ndone, 3);
    ir_m[2] = 32'h1234_5678;
    check("busy_ir", ir[2], ir_m[2]);

    // reset while waiting on the latency-1 instance
    wait_ready(1);
    pc = 32'h0040_0004; req_instr = 1; req_we = 0; mem_rdata = 32'h7777_7777;
    valid[1] = 1'b1;
    @(negedge clk);
    valid[1] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    reset_model();
    check("midrst_ready", ready[1], 1);
    check("midrst_done", done[1], 0);
    check("midrst_ir", ir[1], 0);
    check("midrst_mdr", mdr[1], 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done[1]) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    check("midrst_ir_hold", ir[1], 0);
    do_access(1, 1, 0, 32'h0040_0004, 0, 32'h0123_4567, 0);

    // randomized accesses across all instances
    for (int i = 0; i < 40; i++) begin
      int d, cls;
      logic ins, wr;
      d   = $urandom_range(0, 2);
      cls = $urandom_range(0, 4);
      case (cls)
        0:       a = TB_TEXT + 4 * $urandom_range(0, 1023);
        1:       a = TB_DATA + 4 * $urandom_range(0, 1023);
        2:       a = TB_TEXT + 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
        3:       a = $urandom_range(0, 32'h003F_FFFF);
        default: a = $urandom;
      endcase
      ins = $urandom_range(0, 1);
      wr  = ins ? 1'b0 : 1'(($urandom_range(0, 1)));
      if (cls == 0 && $urandom_range(0, 3) != 0) begin ins = 1; wr = 0; end
      if (cls == 1 && ins && $urandom_range(0, 3) != 0) ins = 0;
      do_access(d, ins, wr, a, $urandom, $urandom, $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mu_mem_access_ctrl.md
Name: mu_mem_access_ctrl

Overview:
- Multicycle memory-access controller between the MIPS datapath and the memory system.
- Selects the fetch address (PC) or the data address (ALU result), checks alignment and region, and translates MIPS virtual addresses into memory-system word addresses.
- Waits the memory read latency, then captures the returned word into the Instruction Register (IR) or the Memory Data Register (MDR).
- Handshakes with the control FSM through a valid/ready request and a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 32, data and address width.
- READ_LATENCY, 1, memory read latency in cycles; legal range 0..3.
- TEXT_BASE, 32'h0040_0000, start of the instruction region (ROM).
- DATA_BASE, 32'h1001_0000, start of the data region (RAM).
- RAM_BOUND, 32'h1000_0000, memory-system boundary; addresses at or above it select RAM.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- req_valid_i  in  1  control FSM requests an access.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = store, 0 = load or fetch.
- req_instr_i  in  1  IorD select: 1 = instruction fetch from pc_i, 0 = data access at alu_addr_i.
- pc_i  in  DATA_WIDTH  program counter.
- alu_addr_i  in  DATA_WIDTH  data address from ALUOut.
- wdata_i  in  DATA_WIDTH  store data.
- mem_rdata_i  in  DATA_WIDTH  read data from the memory system.
- mem_addr_o  out  DATA_WIDTH  translated word address to the memory system.
- mem_wdata_o  out  DATA_WIDTH  store data to the memory system.
- mem_we_o  out  1  memory write enable.
- ir_o  out  DATA_WIDTH  Instruction Register.
- mdr_o  out  DATA_WIDTH  Memory Data Register.
- done_o  out  1  one-cycle pulse: access complete.
- err_o  out  1  one-cycle pulse together with done_o: access rejected.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE, counter = 0.
  - mem_addr_o, mem_wdata_o, mem_we_o, ir_o, mdr_o, done_o and err_o are all 0.
  - req_ready_o = 1 from the first cycle after the reset edge.
  - Reset in any state aborts the access: no capture, and mem_we_o drops in the next cycle.
- States: IDLE, WRITE, WAIT, DONE, ERR.
  - req_ready_o = 1 only in IDLE.
  - done_o = 1 in DONE and in ERR.
  - err_o = 1 only in ERR.
- Acceptance: in cycle 0, IDLE with req_valid_i = 1. The controller registers addr = req_instr_i ? pc_i : alu_addr_i, together with we, instr and wdata. Request inputs are ignored outside IDLE.
- Error check, evaluated at acceptance. Any of the following sends the FSM to ERR:
  - addr[1:0] != 0;
  - addr < TEXT_BASE;
  - TEXT_BASE <= addr < DATA_BASE with we = 1 (store to text);
  - addr >= DATA_BASE with instr = 1 (fetch from data).
- ERR behaviour: no memory access and mem_we_o stays 0. ERR lasts exactly cycle 1, then the FSM returns to IDLE. IR and MDR are unchanged.
- Translation, registered into mem_addr_o at acceptance and held until the FSM returns to IDLE:
  - Text region: mem_addr_o = (addr - TEXT_BASE) >> 2. The result is always < RAM_BOUND.
  - Data region: mem_addr_o = RAM_BOUND + ((addr - DATA_BASE) >> 2).
  - Subtraction is unsigned, DATA_WIDTH bits, with no overflow checking beyond the region checks above.
- Write path:
  - WRITE in cycle 1: mem_we_o = 1 and mem_wdata_o = wdata.
  - DONE in cycle 2.
  - mem_we_o is high for exactly one cycle.
- Read path:
  - WAIT is entered in cycle 1 with counter = 0, and the counter increments each cycle.
  - When counter == READ_LATENCY, mem_rdata_i is captured into ir_o if instr = 1, otherwise into mdr_o. The FSM then moves to DONE.
  - done_o is asserted in cycle 2 + READ_LATENCY. The new IR/MDR value is visible in that same cycle.
  - The register that is not targeted holds its value.
- DONE always returns to IDLE.
  - Back-to-back requests see one IDLE cycle of ready between accesses; the minimum issue interval is 3 + READ_LATENCY cycles.
  - mem_wdata_o holds its last value; it is qualified only by mem_we_o.

Decomposition:
- Shared package (MU_my_pkg) holds:
  - DATA_WIDTH, TEXT_BASE, DATA_BASE, RAM_BOUND;
  - the state enum (IDLE, WRITE, WAIT, DONE, ERR);
  - the access request struct (addr, we, instr, wdata).
- One sub-module, mu_addr_translate: purely combinational region check and translation. Outputs are the translated address and an error flag. The controller instantiates it on the selected address.

Test Plan:
- Fetch: rst_n low 2 cycles then high; pc_i = 32'h0040_0008, req_instr_i = 1, READ_LATENCY = 1, mem_rdata_i = 32'h2008_0005 -> mem_addr_o = 2; done_o in cycle 3; ir_o = 32'h2008_0005; mdr_o = 0.
- Store then load: alu_addr_i = 32'h1001_0004, we = 1, wdata = 32'hDEAD_BEEF -> mem_addr_o = 32'h1000_0001, mem_we_o high in cycle 1 only, done_o in cycle 2. A following load at the same address with mem_rdata_i = 32'hDEAD_BEEF -> mdr_o = 32'hDEAD_BEEF and ir_o unchanged.
- Errors:
  - alu_addr_i = 32'h1001_0002 -> done_o and err_o in cycle 1, mem_we_o never high.
  - Store to 32'h0040_0000 -> err_o.
  - Fetch from 32'h1001_0000 -> err_o.
  - Address 32'h0000_0010 -> err_o.
- Busy handling: req_valid_i held high continuously -> req_ready_o low from cycle 1 until the FSM returns to IDLE; exactly one access per ready cycle; no duplicated done_o.
- Reset mid-operation: rst_n low during WAIT -> next cycle IDLE, ir_o = mdr_o = 0, no done_o; the next fetch completes normally.
- Latency sweep: READ_LATENCY = 0 and 3 -> done_o in cycle 2 and cycle 5 respectively; captured value equals mem_rdata_i sampled at the capture edge.
